// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX-stage issue logic and the
// iterative multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rd_data;

  modport master (
    output in_valid, op, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, rd_data
  );

  modport slave (
    input  in_valid, op, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, rd_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Bit-serial RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, sign fix-up in a single cycle at the end.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [XLEN-1:0]   ZERO_X  = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONES_X  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   MIN_X   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2*XLEN-1:0] ZERO_2X = {(2*XLEN){1'b0}};
  localparam logic [XLEN:0]     ZERO_R  = {(XLEN+1){1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LD  = CNT_W'(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e            state_q, state_d, state_nx_s;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
  logic              out_valid_q, out_valid_d;

  logic              accept_s;
  logic              rs1_signed_s, rs2_signed_s;
  logic              s1_neg_s, s2_neg_s;
  logic [XLEN-1:0]   mag1_s, mag2_s;
  logic              div_zero_s, ovf_s, fast_s;
  logic [XLEN-1:0]   fast_res_s;
  logic [XLEN-1:0]   mul_add_s;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_shift_s, div_diff_s, div_rem_s;
  logic              div_bit_s;
  logic [2*XLEN-1:0] mul_res_s;
  logic [XLEN-1:0]   quo_res_s, rem_res_s, result_s;

  assign accept_s = bus.in_valid && !bus.flush;

  // MUL needs no signedness: its low half is the same for signed and unsigned operands.
  assign rs1_signed_s = (bus.op == 3'b001) || (bus.op == 3'b010) ||
                        (bus.op == 3'b100) || (bus.op == 3'b110);
  assign rs2_signed_s = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
  assign s1_neg_s     = rs1_signed_s && bus.rs1_data[XLEN-1];
  assign s2_neg_s     = rs2_signed_s && bus.rs2_data[XLEN-1];
  assign mag1_s       = s1_neg_s ? (ZERO_X - bus.rs1_data) : bus.rs1_data;
  assign mag2_s       = s2_neg_s ? (ZERO_X - bus.rs2_data) : bus.rs2_data;

  assign div_zero_s = bus.op[2] && (bus.rs2_data == ZERO_X);
  assign ovf_s      = ((bus.op == 3'b100) || (bus.op == 3'b110)) &&
                      (bus.rs1_data == MIN_X) && (bus.rs2_data == ONES_X);
  assign fast_s     = div_zero_s || ovf_s;

  // Architecturally fixed results for divide-by-zero and signed overflow.
  always_comb begin
    if (bus.op[1]) begin
      fast_res_s = div_zero_s ? bus.rs1_data : ZERO_X;
    end else begin
      fast_res_s = div_zero_s ? ONES_X : MIN_X;
    end
  end

  // Multiply step: the low half holds the unconsumed multiplier bits.
  assign mul_add_s = prod_q[0] ? opnd_q : ZERO_X;
  assign mul_sum_s = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mul_add_s};

  // Divide step: the low half shifts the dividend out MSB-first and the quotient in.
  assign div_shift_s = {rem_q[XLEN-1:0], prod_q[XLEN-1]};
  assign div_diff_s  = div_shift_s - {1'b0, opnd_q};
  assign div_bit_s   = ~div_diff_s[XLEN];
  assign div_rem_s   = div_bit_s ? div_diff_s : div_shift_s;

  assign mul_res_s = neg_res_q ? (ZERO_2X - prod_q) : prod_q;
  assign quo_res_s = neg_res_q ? (ZERO_X - prod_q[XLEN-1:0]) : prod_q[XLEN-1:0];
  assign rem_res_s = neg_rem_q ? (ZERO_X - rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];

  // Final result selection by operation.
  always_comb begin
    case (op_q)
      3'b000:                 result_s = mul_res_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_s = mul_res_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result_s = quo_res_s;
      3'b110, 3'b111:         result_s = rem_res_s;
      default:                result_s = ZERO_X;
    endcase
  end

  // Next-state and datapath update; flush overrides the natural next state.
  always_comb begin
    state_nx_s = state_q;
    op_d       = op_q;
    opnd_d     = opnd_q;
    prod_d     = prod_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_d      = bus.op;
          neg_res_d = s1_neg_s ^ s2_neg_s;
          neg_rem_d = s1_neg_s;
          cnt_d     = CNT_LD;
          rem_d     = ZERO_R;
          if (bus.op[2]) begin
            opnd_d = mag2_s;
            prod_d = {ZERO_X, mag1_s};
          end else begin
            opnd_d = mag1_s;
            prod_d = {ZERO_X, mag2_s};
          end
          if (fast_s) begin
            rd_data_d  = fast_res_s;
            state_nx_s = DONE;
          end else begin
            state_nx_s = CALC;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      CALC: begin
        cnt_d = cnt_q - CNT_ONE;
        if (op_q[2]) begin
          rem_d  = div_rem_s;
          prod_d = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], div_bit_s};
        end else begin
          prod_d = {mul_sum_s, prod_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_ONE) begin
          state_nx_s = FIX;
        end else begin
          state_nx_s = CALC;
        end
      end
      FIX: begin
        rd_data_d  = result_s;
        state_nx_s = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
    state_d     = bus.flush ? IDLE : state_nx_s;
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= 3'b000;
      opnd_q      <= ZERO_X;
      prod_q      <= ZERO_2X;
      rem_q       <= ZERO_R;
      cnt_q       <= {CNT_W{1'b0}};
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      rd_data_q   <= ZERO_X;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opnd_q      <= opnd_d;
      prod_q      <= prod_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      rd_data_q   <= rd_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.rd_data   = rd_data_q;

endmodule
